// File: rtl/common_pkg.sv
// Types and constants shared by the pipeline stages: control word, funct3 encodings, LSU states.
package common;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } control_type;

    typedef enum logic {IDLE, REQ} lsu_state_t;

    // log2 of the access size in bytes; doubleword accesses collapse to word on a 32-bit datapath
    function automatic logic [1:0] access_size(input logic [2:0] funct3, input int xlen);
        logic [1:0] size;
        size = funct3[1:0];
        if (xlen == 32 && size == 2'd3) size = 2'd2;
        return size;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Shifts the addressed lane of a read word down to bit 0 and sign/zero-extends it per funct3.
module mem_load_align
    import common::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]            d_rdata,
    input  logic [$clog2(XLEN/8)-1:0]  off,
    input  logic [2:0]                 funct3,
    output logic [XLEN-1:0]            load_data
);

    logic [XLEN-1:0] shifted;

    assign shifted = d_rdata >> {off, 3'b000};

    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_LB:  load_data = XLEN'($signed(shifted[7:0]));
            F3_LH:  load_data = XLEN'($signed(shifted[15:0]));
            F3_LW:  load_data = XLEN'($signed(shifted[31:0]));
            F3_LBU: load_data = XLEN'(shifted[7:0]);
            F3_LHU: load_data = XLEN'(shifted[15:0]);
            // On a 32-bit datapath LWU and LD have no meaning and behave as LW
            F3_LWU: load_data = (XLEN == 64) ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            F3_LD:  load_data = (XLEN == 64) ? shifted : XLEN'($signed(shifted[31:0]));
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Handshaked memory stage: issues one req/ack bus transaction per aligned load/store and
// returns formatted results with a one-cycle out_valid pulse.
module mem_access_unit
    import common::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     alu_data_in,
    input  logic [XLEN-1:0]     store_data_in,
    input  control_type         control_in,
    output logic                out_valid,
    output logic [XLEN-1:0]     alu_data_out,
    output logic [XLEN-1:0]     memory_data_out,
    output control_type         control_out,
    output logic                misaligned,
    output logic                d_req,
    output logic                d_we,
    output logic [ADDR_W-1:0]   d_addr,
    output logic [XLEN/8-1:0]   d_be,
    output logic [XLEN-1:0]     d_wdata,
    input  logic                d_ack,
    input  logic [XLEN-1:0]     d_rdata
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);

    lsu_state_t        state_reg, state_next;
    logic [OFF_W-1:0]  off_in, off_reg, lane_mask;
    logic [1:0]        size_in;
    logic              mem_op, mis_in;
    logic [BE_W-1:0]   be_base, be_in;
    logic [XLEN-1:0]   wdata_in, load_data;

    assign off_in = alu_data_in[OFF_W-1:0];
    assign mem_op = control_in.mem_read | control_in.mem_write;

    always_comb begin
        size_in   = access_size(control_in.funct3, XLEN);
        mis_in    = 1'b0;
        be_base   = '1;
        lane_mask = '1;
        case (size_in)
            2'd0: begin be_base = BE_W'(1);  lane_mask = '0;           end
            2'd1: begin be_base = BE_W'(3);  lane_mask = OFF_W'(1); mis_in = off_in[0];          end
            2'd2: begin be_base = BE_W'(15); lane_mask = OFF_W'(3); mis_in = off_in[1:0] != 2'd0; end
            default: mis_in = off_in != '0;
        endcase
        be_in = be_base << off_in;
    end

    // Each byte lane takes the store byte at (lane index mod access size), replicating the datum
    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_lane
            localparam logic [OFF_W-1:0] LANE = OFF_W'(gi);
            logic [OFF_W-1:0] src;
            assign src = LANE & lane_mask;
            assign wdata_in[gi*8 +: 8] = store_data_in[{src, 3'b000} +: 8];
        end
    endgenerate

    mem_load_align #(.XLEN(XLEN)) u_align (
        .d_rdata   (d_rdata),
        .off       (off_reg),
        .funct3    (control_out.funct3),
        .load_data (load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        d_req      = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && mem_op && !mis_in) state_next = REQ;
            end
            REQ: begin
                d_req = 1'b1;
                if (d_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid       <= 1'b0;
            misaligned      <= 1'b0;
            alu_data_out    <= '0;
            memory_data_out <= '0;
            control_out     <= '0;
            d_we            <= 1'b0;
            d_addr          <= '0;
            d_be            <= '0;
            d_wdata         <= '0;
            off_reg         <= '0;
        end else begin
            out_valid  <= 1'b0;
            misaligned <= 1'b0;
            if (state_reg == IDLE && in_valid) begin
                alu_data_out    <= alu_data_in;
                control_out     <= control_in;
                memory_data_out <= '0;
                if (!mem_op) begin
                    out_valid <= 1'b1;
                end else if (mis_in) begin
                    out_valid  <= 1'b1;
                    misaligned <= 1'b1;
                end else begin
                    d_we    <= control_in.mem_write;
                    d_addr  <= {alu_data_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    d_be    <= be_in;
                    d_wdata <= wdata_in;
                    off_reg <= off_in;
                end
            end else if (state_reg == REQ && d_ack) begin
                out_valid       <= 1'b1;
                memory_data_out <= control_out.mem_read ? load_data : '0;
            end
        end
    end

endmodule
